// File: rtl/huffman_block_sequencer.sv
// Huffman block sequencer: walks one 64-coefficient zig-zag block, forms the
// DC difference and (run,size) symbols, looks the code up in an external table
// and hands registered code/amplitude pairs to a downstream bit packer.
module huffman_block_sequencer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic        dc_clear,
  input  logic [11:0] coeff_in,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  output logic [3:0]  lut_run,
  output logic [3:0]  lut_size,
  output logic        lut_is_dc,
  input  logic [15:0] lut_code,
  input  logic [4:0]  lut_len,
  output logic [15:0] out_code,
  output logic [4:0]  out_code_len,
  output logic [10:0] out_amp,
  output logic [3:0]  out_amp_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] EMIT_ZRL = 3'd2;
  localparam logic [2:0] EMIT_SYM = 3'd3;
  localparam logic [2:0] EMIT_EOB = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;

  // Bit length of |v|; v is a 13-bit two's complement value.
  function automatic logic [3:0] size_of(input logic [12:0] v);
    logic [12:0] mag;
    logic [3:0]  s;
    mag = v[12] ? (~v + 13'd1) : v;
    s   = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

  // Amplitude bits: low s bits of v (v > 0) or of v - 1 (v < 0).
  function automatic logic [10:0] amp_of(input logic [12:0] v, input logic [3:0] s);
    logic [12:0] t;
    logic [12:0] mask;
    t    = v[12] ? (v - 13'd1) : v;
    mask = (13'd1 << s) - 13'd1;
    t    = t & mask;
    return t[10:0];
  endfunction

  logic [2:0]  state_r, state_n;
  logic [5:0]  idx_r;
  logic        last_r;
  logic [5:0]  run_r, run_n;
  logic [11:0] dc_pred_r;
  logic [12:0] value_r, value_s;
  logic [3:0]  size_s;
  logic [3:0]  amp_len_s;
  logic [10:0] amp_s;
  logic [5:0]  run_sub_s;
  logic        xfer_s, accept_s, load_s, coeff_zero_s;

  assign xfer_s       = coeff_ready && coeff_valid;
  assign accept_s     = out_valid && out_ready;
  assign coeff_zero_s = (coeff_in == 12'd0);
  assign run_sub_s    = run_r - 6'd16;
  assign size_s       = size_of(value_s);
  assign amp_s        = amp_of(value_s, amp_len_s);

  // Value being coded: DC difference or AC coefficient in FETCH, held value after a ZRL.
  always_comb begin
    value_s = value_r;
    if (state_r == FETCH) begin
      if (idx_r == 6'd0) begin
        value_s = {coeff_in[11], coeff_in} - {dc_pred_r[11], dc_pred_r};
      end else begin
        value_s = {coeff_in[11], coeff_in};
      end
    end else begin
      value_s = value_r;
    end
  end

  // Symbol that would be loaded on this edge, shown to the external table.
  always_comb begin
    lut_run   = 4'd0;
    lut_size  = 4'd0;
    lut_is_dc = 1'b0;
    amp_len_s = 4'd0;
    case (state_r)
      FETCH: begin
        if (idx_r == 6'd0) begin
          lut_is_dc = 1'b1;
          lut_size  = size_s;
          amp_len_s = size_s;
        end else if (coeff_zero_s) begin
          lut_run   = 4'd0;            // only consumed as EOB at index 63
        end else if (run_r >= 6'd16) begin
          lut_run   = 4'd15;           // ZRL
        end else begin
          lut_run   = run_r[3:0];
          lut_size  = size_s;
          amp_len_s = size_s;
        end
      end
      EMIT_ZRL: begin
        if (run_sub_s >= 6'd16) begin
          lut_run   = 4'd15;
        end else begin
          lut_run   = run_sub_s[3:0];
          lut_size  = size_s;
          amp_len_s = size_s;
        end
      end
      default: begin
        lut_run = 4'd0;
      end
    endcase
  end

  // Next-state, run bookkeeping and symbol-load decision.
  always_comb begin
    state_n = state_r;
    run_n   = run_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          run_n   = 6'd0;
        end else begin
          state_n = IDLE;
        end
      end
      FETCH: begin
        if (!xfer_s) begin
          state_n = FETCH;
        end else if (idx_r == 6'd0) begin
          state_n = EMIT_SYM;
          run_n   = 6'd0;
          load_s  = 1'b1;
        end else if (coeff_zero_s) begin
          run_n = run_r + 6'd1;
          if (idx_r == 6'd63) begin
            state_n = EMIT_EOB;
            load_s  = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end else if (run_r >= 6'd16) begin
          state_n = EMIT_ZRL;
          load_s  = 1'b1;
        end else begin
          state_n = EMIT_SYM;
          load_s  = 1'b1;
        end
      end
      EMIT_ZRL: begin
        if (accept_s) begin
          run_n   = run_sub_s;
          load_s  = 1'b1;
          state_n = (run_sub_s >= 6'd16) ? EMIT_ZRL : EMIT_SYM;
        end else begin
          state_n = EMIT_ZRL;
        end
      end
      EMIT_SYM: begin
        if (accept_s) begin
          run_n   = 6'd0;
          state_n = last_r ? FINISH : FETCH;
        end else begin
          state_n = EMIT_SYM;
        end
      end
      EMIT_EOB: begin
        if (accept_s) begin
          state_n = FINISH;
        end else begin
          state_n = EMIT_EOB;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sequencer state: FSM, coefficient index, zero run, DC predictor, held value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= IDLE;
      idx_r     <= 6'd0;
      last_r    <= 1'b0;
      run_r     <= 6'd0;
      dc_pred_r <= 12'd0;
      value_r   <= 13'd0;
    end else begin
      state_r <= state_n;
      run_r   <= run_n;
      if (state_r == IDLE) begin
        if (dc_clear) dc_pred_r <= 12'd0;
        if (start) begin
          idx_r  <= 6'd0;
          last_r <= 1'b0;
        end
      end
      if (xfer_s) begin
        value_r <= value_s;
        if (idx_r == 6'd0) dc_pred_r <= coeff_in;
        if (idx_r == 6'd63) last_r <= 1'b1;
        else                idx_r  <= idx_r + 6'd1;
      end
    end
  end

  // Registered outputs: status flags from the next state, symbol fields on load.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      coeff_ready  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      out_valid    <= 1'b0;
      out_code     <= 16'd0;
      out_code_len <= 5'd0;
      out_amp      <= 11'd0;
      out_amp_len  <= 4'd0;
    end else begin
      coeff_ready <= (state_n == FETCH);
      busy        <= (state_n != IDLE);
      done        <= (state_n == FINISH);
      if (load_s) begin
        out_valid    <= 1'b1;
        out_code     <= lut_code;
        out_code_len <= lut_len;
        out_amp      <= amp_s;
        out_amp_len  <= amp_len_s;
      end else if (accept_s) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_block_sequencer.sv
// Directed bench for huffman_block_sequencer with a transparent stand-in
// Huffman table: code = {is_dc, run, size}, length = size + 1.
module tb_huffman_block_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start = 1'b0;
  logic        dc_clear = 1'b0;
  logic [11:0] coeff_in = 12'd0;
  logic        coeff_valid = 1'b0;
  logic        coeff_ready;
  logic [3:0]  lut_run, lut_size;
  logic        lut_is_dc;
  logic [15:0] lut_code;
  logic [4:0]  lut_len;
  logic [15:0] out_code;
  logic [4:0]  out_code_len;
  logic [10:0] out_amp;
  logic [3:0]  out_amp_len;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  assign lut_code = {7'd0, lut_is_dc, lut_run, lut_size};
  assign lut_len  = {1'b0, lut_size} + 5'd1;

  huffman_block_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .dc_clear(dc_clear),
    .coeff_in(coeff_in), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .lut_run(lut_run), .lut_size(lut_size), .lut_is_dc(lut_is_dc),
    .lut_code(lut_code), .lut_len(lut_len),
    .out_code(out_code), .out_code_len(out_code_len),
    .out_amp(out_amp), .out_amp_len(out_amp_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic clr);
    start = 1'b1; dc_clear = clr;
    @(negedge clk_in);
    start = 1'b0; dc_clear = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send(input logic [11:0] v);
    int n;
    coeff_in = v; coeff_valid = 1'b1; n = 0;
    while (!coeff_ready && n < 40) begin
      @(negedge clk_in); n++;
    end
    chk("coeff_ready_wait", coeff_ready, 1);
    @(negedge clk_in);
    coeff_valid = 1'b0; coeff_in = 12'd0;
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send(12'd0);
  endtask

  // Expect a symbol already valid (1-cycle latency), optionally stall, then accept it.
  task automatic take(input string tag, input logic dc, input logic [3:0] run,
                      input logic [3:0] size, input logic [10:0] amp,
                      input logic [3:0] alen, input int stall);
    logic [15:0] ec;
    logic [4:0]  el;
    ec = {7'd0, dc, run, size};
    el = {1'b0, size} + 5'd1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_code"}, out_code, ec);
    chk({tag, "_len"}, out_code_len, el);
    chk({tag, "_amp"}, out_amp, amp);
    chk({tag, "_alen"}, out_amp_len, alen);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_in);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_code"}, out_code, ec);
      chk({tag, "_hold_amp"}, {out_amp_len, out_amp}, {alen, amp});
      chk({tag, "_hold_cready"}, coeff_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk_in);
    out_ready = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ovalid_low"}, out_valid, 0);
    @(negedge clk_in);
    chk({tag, "_done_fall"}, done, 0);
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_cready", coeff_ready, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_code", out_code, 0);

    // Zero-AC block: DC 5 against predictor 0, then EOB.
    do_start(1'b0);
    send(12'd5);
    take("t1_dc", 1'b1, 4'd0, 4'd3, 11'd5, 4'd3, 0);
    send_zeros(63);
    take("t1_eob", 1'b0, 4'd0, 4'd0, 11'd0, 4'd0, 0);
    expect_done("t1");

    // Negative difference (3 - 5 = -2), AC -1, backpressure of 5 cycles per symbol.
    do_start(1'b0);
    send(12'd3);
    take("t2_dc", 1'b1, 4'd0, 4'd2, 11'd1, 4'd2, 5);
    send(12'hFFF);
    take("t2_ac1", 1'b0, 4'd0, 4'd1, 11'd0, 4'd1, 5);
    send_zeros(62);
    take("t2_eob", 1'b0, 4'd0, 4'd0, 11'd0, 4'd0, 5);
    expect_done("t2");

    // start with dc_clear: DC -4 coded against 0; long runs; AC63 = -1024.
    do_start(1'b1);
    send(12'hFFC);
    take("t3_dc", 1'b1, 4'd0, 4'd3, 11'd3, 4'd3, 0);
    send_zeros(33);
    send(12'd7);
    take("t3_zrl0", 1'b0, 4'd15, 4'd0, 11'd0, 4'd0, 0);
    take("t3_zrl1", 1'b0, 4'd15, 4'd0, 11'd0, 4'd0, 0);
    take("t3_sym", 1'b0, 4'd1, 4'd3, 11'd7, 4'd3, 0);
    send_zeros(28);
    send(12'hC00);
    take("t3_zrl2", 1'b0, 4'd15, 4'd0, 11'd0, 4'd0, 0);
    take("t3_last", 1'b0, 4'd12, 4'd11, 11'h3FF, 4'd11, 0);
    expect_done("t3");

    // DC -4 against -4 (size 0); stray start/dc_clear mid-block; AC63 = 1 after 62 zeros.
    do_start(1'b0);
    send(12'hFFC);
    take("t4_dc", 1'b1, 4'd0, 4'd0, 11'd0, 4'd0, 0);
    start = 1'b1; dc_clear = 1'b1;
    send_zeros(62);
    start = 1'b0; dc_clear = 1'b0;
    send(12'd1);
    take("t4_zrl0", 1'b0, 4'd15, 4'd0, 11'd0, 4'd0, 0);
    take("t4_zrl1", 1'b0, 4'd15, 4'd0, 11'd0, 4'd0, 0);
    take("t4_zrl2", 1'b0, 4'd15, 4'd0, 11'd0, 4'd0, 0);
    take("t4_sym", 1'b0, 4'd14, 4'd1, 11'd1, 4'd1, 0);
    expect_done("t4");

    // DC 9 against -4 (diff 13), reset after 20 coefficients, fresh block codes DC against 0.
    do_start(1'b0);
    send(12'd9);
    take("t5_dc", 1'b1, 4'd0, 4'd4, 11'd13, 4'd4, 0);
    send_zeros(19);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("t5_rst_ovalid", out_valid, 0);
    chk("t5_rst_cready", coeff_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_code", out_code, 0);
    @(negedge clk_in);
    chk("t5_idle_ovalid", out_valid, 0);
    do_start(1'b0);
    send(12'd9);
    take("t5_dc2", 1'b1, 4'd0, 4'd4, 11'd9, 4'd4, 0);
    send_zeros(63);
    take("t5_eob", 1'b0, 4'd0, 4'd0, 11'd0, 4'd0, 0);
    expect_done("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huffman_block_sequencer.md
HUFFMAN_BLOCK_SEQUENCER -- requirements
Module: huffman_block_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports SHALL be as listed in REQ-002..REQ-016.
REQ-002 clk_in  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous to clk_in, active-high.
REQ-004 start  input  1  one-cycle pulse that begins one 64-coefficient block; ignored unless in IDLE.
REQ-005 dc_clear  input  1  when high in IDLE, sets the DC predictor to 0 on the next edge.
REQ-006 coeff_in  input  12  signed zig-zag-ordered coefficient; index 0 is DC and indices 1..63 are AC.
REQ-007 coeff_valid / coeff_ready  input / output  1 / 1  coefficient handshake; a transfer occurs when both are high.
REQ-008 lut_run, lut_size  output  4 / 4  (run,size) symbol presented to the external combinational Huffman table.
REQ-009 lut_is_dc  output  1  selects the DC table when high and the AC table when low.
REQ-010 lut_code, lut_len  input  16 / 5  table result, right-aligned code and its bit length (1..16).
REQ-011 out_code, out_code_len  output  16 / 5  registered Huffman code and its length.
REQ-012 out_amp, out_amp_len  output  11 / 4  registered amplitude bits (right-aligned) and their length (0..11).
REQ-013 out_valid / out_ready  output / input  1 / 1  symbol handshake to the bit packer.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse after the last symbol of the block is accepted.
REQ-016 There SHALL be no parameters; the block size is fixed at 64.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, EMIT_ZRL, EMIT_SYM, EMIT_EOB and FINISH.
- IDLE: start -> FETCH, coefficient index = 0, run = 0.
REQ-018 FETCH SHALL assert coeff_ready, and on each transfer it SHALL behave as follows:
- index 0: value = coeff_in - dc_pred (13-bit signed); dc_pred <= coeff_in; -> EMIT_SYM with lut_is_dc = 1 and run = 0.
- index 1..63, zero coefficient: run <= run + 1; no symbol; stay in FETCH unless index = 63.
- index 1..63, nonzero coefficient: if run >= 16 -> EMIT_ZRL, else -> EMIT_SYM.
REQ-019 coeff_ready SHALL be low in every state except FETCH, so that at most one coefficient is pending.
REQ-020 Size SHALL be the bit length of |value| (0 for 0, 11 for 1024..2047); size SHALL be driven on lut_size.
REQ-021 Amplitude bits SHALL be the low size bits of value when value > 0, and of value - 1 when value < 0; bits above out_amp_len SHALL be 0.
REQ-022 EMIT_ZRL SHALL present (15,0) with lut_is_dc = 0 and amp_len = 0; on acceptance run <= run - 16, then it SHALL repeat while run >= 16, else go to EMIT_SYM.
REQ-023 EMIT_SYM SHALL present (run,size); on acceptance run <= 0, then it SHALL go to FETCH, or to FINISH if index 63 was consumed.
REQ-024 If index 63 is zero, the FSM SHALL go to EMIT_EOB, which presents (0,0) with amp_len = 0 and goes to FINISH on acceptance.
- Trailing zero runs of 16 or more SHALL produce no ZRL, only EOB.
REQ-025 If index 63 is nonzero, no EOB SHALL be emitted.
REQ-026 On entry to any EMIT state, out_code/out_code_len SHALL be registered from lut_code/lut_len and out_valid SHALL be set.
- Symbol latency SHALL be 1 cycle from the coefficient transfer (or from the previous acceptance) to out_valid.
REQ-027 While out_valid is high and out_ready is low, all out_* fields SHALL stay stable; out_valid SHALL never drop without acceptance.
REQ-028 After acceptance, out_valid SHALL fall in the next cycle unless a further symbol is loaded in that same cycle, giving back-to-back ZRLs at 1 symbol/cycle.
REQ-029 FINISH SHALL pulse done for exactly one cycle, then go to IDLE; busy SHALL be low in that IDLE cycle.
REQ-030 start SHALL be ignored outside IDLE, and dc_clear SHALL be ignored outside IDLE.
REQ-031 If start and dc_clear coincide in IDLE, the predictor SHALL be cleared before index 0 is used.

Reset
REQ-032 rst_in SHALL force IDLE and clear index, run and dc_pred to 0.
- Outputs SHALL go to 0: out_valid, coeff_ready, busy, done, out_*.
REQ-033 A reset mid-block SHALL discard the partial block without emitting EOB; the next start SHALL begin a fresh block at index 0.

Verification
REQ-034 Zero AC block: dc_pred = 0, DC = 5, 63 AC zeros -> DC (0,3) with amp = 101; then EOB (0,0); then done; 2 symbols total.
REQ-035 Negative value and predictor: previous DC = 5, new DC = 3 -> diff = -2, (0,2) with amp = 01; AC[1] = -1 -> (0,1) with amp = 0; remaining AC zero -> EOB.
REQ-036 Long run: AC[1..33] = 0 and AC[34] = 7 -> two ZRLs (15,0), then (1,3) with amp = 111; no EOB if AC[63] != 0.
REQ-037 Backpressure: out_ready held low for 5 cycles on every symbol -> fields stable throughout; coeff_ready low meanwhile; no symbols lost or duplicated.
REQ-038 Boundary: AC[63] = 1 with AC[1..62] = 0 -> 3 ZRLs, then (14,1); no EOB; done 1 cycle after acceptance.
REQ-039 Reset after 20 coefficients, then a new start -> no stray out_valid; dc_pred = 0; the next block's DC is coded against 0.
